// File: rtl/pri_encoder_pkg.sv
// Shared definitions for the registered priority encoder.
package pri_encoder_pkg;

    // Arbitration mode selected by the mode input
    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Ceiling log2 for index widths; callers guarantee v >= 2
    function automatic int clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return int'(r);
    endfunction

endpackage

// File: rtl/pri_find_n.sv
// Combinational search for the highest set bit at or below a start index,
// wrapping from bit 0 to bit N-1.
module pri_find_n
    import pri_encoder_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = clog2_f(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W-1:0] w_pos;

    // Walk start, start-1, ... 0, N-1, ... start+1; first set bit wins
    always_comb begin
        idx   = '0;
        found = 1'b0;
        w_pos = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (start >= W'(k)) w_pos = start - W'(k);
            else                w_pos = start + W'(N - k);
            if (!found && vec[w_pos]) begin
                found = 1'b1;
                idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/pri_encoder_q.sv
// Registered N-line priority encoder with pending capture, per-line mask,
// fixed or round-robin selection, and a valid/ready index output.
module pri_encoder_q
    import pri_encoder_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = clog2_f(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         mode,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         none
);

    logic [N-1:0] r_pend;
    logic         r_valid;
    logic [W-1:0] r_idx;
    logic [W-1:0] r_rr_ptr;
    logic         r_none;

    logic         w_acc;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_pend_next;
    logic [N-1:0] w_cand;
    logic [W-1:0] w_start;
    logic [W-1:0] w_sel;
    logic         w_found;
    logic         w_load;

    // Accept, clear vector, next pending and the candidate set for this load.
    // New requests are kept out of the candidates so they wait one cycle.
    always_comb begin
        w_acc = r_valid & out_ready;
        w_clr = '0;
        if (w_acc) w_clr[r_idx] = 1'b1;
        w_pend_next = (r_pend & ~w_clr) | req;
        w_cand      = r_pend & ~w_clr & mask;
        w_load      = ~r_valid | w_acc;
        if (mode_e'(mode) == MODE_RR)
            w_start = (r_rr_ptr == '0) ? W'(N - 1) : r_rr_ptr - W'(1);
        else
            w_start = W'(N - 1);
    end

    pri_find_n #(.N(N)) u_find (
        .vec   (w_cand),
        .start (w_start),
        .idx   (w_sel),
        .found (w_found)
    );

    // Pending register, empty flag and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend   <= '0;
            r_none   <= 1'b1;
            r_rr_ptr <= '0;
        end else begin
            r_pend <= w_pend_next;
            r_none <= ~|(w_pend_next & mask);
            if (w_acc) r_rr_ptr <= r_idx;
        end
    end

    // Output holding register: reloads only when empty or just accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else if (w_load) begin
            r_valid <= w_found;
            if (w_found) r_idx <= w_sel;
        end
    end

    assign out_idx   = r_idx;
    assign out_valid = r_valid;
    assign pending   = r_pend;
    assign none      = r_none;

endmodule

// File: tb/tb_pri_encoder_q.sv
// Bench for pri_encoder_q: an 8-line and a 5-line instance share clock and
// reset and are tracked by a behavioural model of the selection rules.
module tb_pri_encoder_q;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] req8, mask8, pend8;
    logic       mode8, rdy8, valid8, none8;
    logic [2:0] idx8;
    logic [4:0] req5, mask5, pend5;
    logic       mode5, rdy5, valid5, none5;
    logic [2:0] idx5;

    pri_encoder_q #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req8), .mask(mask8), .mode(mode8),
        .out_idx(idx8), .out_valid(valid8), .out_ready(rdy8),
        .pending(pend8), .none(none8)
    );

    pri_encoder_q #(.N(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .mask(mask5), .mode(mode5),
        .out_idx(idx5), .out_valid(valid5), .out_ready(rdy5),
        .pending(pend5), .none(none5)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state, index 0 = N=8 instance, index 1 = N=5 instance
    logic [63:0] m_pend [2];
    logic        m_valid[2];
    int          m_idx  [2];
    int          m_rr   [2];
    logic        m_none [2];

    // Descending search from (ptr-1) mod n in round-robin, from n-1 otherwise
    function automatic int ref_pick(logic [63:0] cand, int n, logic rr, int ptr);
        int start;
        start = rr ? (ptr + n - 1) % n : n - 1;
        for (int k = 0; k < n; k++) begin
            if (cand[(start - k + n) % n]) return (start - k + n) % n;
        end
        return 0;
    endfunction

    // One clock: predict from current inputs, take the edge, commit prediction
    task automatic cyc();
        logic [63:0] rq[2], mk[2], np[2];
        logic md[2], rd[2], nv[2], nn[2];
        int ni[2], nr[2];
        rq[0] = 64'(req8);  mk[0] = 64'(mask8); md[0] = mode8; rd[0] = rdy8;
        rq[1] = 64'(req5);  mk[1] = 64'(mask5); md[1] = mode5; rd[1] = rdy5;
        for (int d = 0; d < 2; d++) begin
            int n;
            logic acc;
            logic [63:0] clr, cand, pnx;
            n    = (d == 0) ? 8 : 5;
            acc  = m_valid[d] & rd[d];
            clr  = acc ? (64'd1 << m_idx[d]) : 64'd0;
            pnx  = (m_pend[d] & ~clr) | rq[d];
            cand = m_pend[d] & ~clr & mk[d];
            np[d] = pnx;
            nv[d] = m_valid[d];
            ni[d] = m_idx[d];
            nr[d] = acc ? m_idx[d] : m_rr[d];
            nn[d] = ((pnx & mk[d]) == 64'd0);
            if (!m_valid[d] || acc) begin
                nv[d] = (cand != 64'd0);
                if (cand != 64'd0) ni[d] = ref_pick(cand, n, md[d], m_rr[d]);
            end
            if (!rst_n) begin
                np[d] = '0; nv[d] = 1'b0; ni[d] = 0; nr[d] = 0; nn[d] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = np[d]; m_valid[d] = nv[d]; m_idx[d] = ni[d];
            m_rr[d] = nr[d];   m_none[d] = nn[d];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req8 = '0; mask8 = 8'hFF; mode8 = 1'b0; rdy8 = 1'b0;
        req5 = '0; mask5 = 5'h1F; mode5 = 1'b0; rdy5 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rst_n = 1'b1;
            cyc();
            n_vec++;
            if ({valid8, none8, pend8, idx8} !== {1'b0, 1'b1, 8'h00, 3'd0}) begin
                n_err++;
                $display("FAIL reset[%0d] got v=%0b none=%0b pend=%h idx=%0d want v=0 none=1 pend=00 idx=0",
                         i, valid8, none8, pend8, idx8);
            end
            n_vec++;
            if ({valid5, none5, pend5, idx5} !== {1'b0, 1'b1, 5'h00, 3'd0}) begin
                n_err++;
                $display("FAIL reset5[%0d] got v=%0b none=%0b pend=%h idx=%0d want v=0 none=1 pend=00 idx=0",
                         i, valid5, none5, pend5, idx5);
            end
        end
    endtask

    task automatic test_fixed();
        logic [7:0] ep[5] = '{8'h2C, 8'h2C, 8'h0C, 8'h04, 8'h00};
        logic       ev[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] ei[5] = '{3'd0, 3'd5, 3'd3, 3'd2, 3'd2};
        logic       en[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        mode8 = 1'b0; mask8 = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            req8 = (i == 0) ? 8'h2C : 8'h00;
            rdy8 = (i >= 2);
            cyc();
            n_vec++;
            if ({valid8, idx8, pend8, none8} !== {ev[i], ei[i], ep[i], en[i]}) begin
                n_err++;
                $display("FAIL fixed[%0d] got v=%0b idx=%0d pend=%h none=%0b want v=%0b idx=%0d pend=%h none=%0b",
                         i, valid8, idx8, pend8, none8, ev[i], ei[i], ep[i], en[i]);
            end
        end
        rdy8 = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] ep[6] = '{8'h01, 8'h01, 8'h81, 8'h81, 8'h80, 8'h00};
        logic       ev[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] ei[6] = '{3'd2, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7};
        mode8 = 1'b0; mask8 = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            req8 = (i == 0) ? 8'h01 : (i == 2) ? 8'h80 : 8'h00;
            rdy8 = (i >= 4);
            cyc();
            n_vec++;
            if ({valid8, idx8, pend8} !== {ev[i], ei[i], ep[i]}) begin
                n_err++;
                $display("FAIL backpressure[%0d] got v=%0b idx=%0d pend=%h want v=%0b idx=%0d pend=%h",
                         i, valid8, idx8, pend8, ev[i], ei[i], ep[i]);
            end
        end
        rdy8 = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [2:0] eg[6] = '{3'd7, 3'd4, 3'd0, 3'd7, 3'd4, 3'd0};
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        mode8 = 1'b1; mask8 = 8'hFF; req8 = 8'h91; rdy8 = 1'b1;
        cyc();
        n_vec++;
        if ({valid8, pend8} !== {1'b0, 8'h91}) begin
            n_err++;
            $display("FAIL rr_first got v=%0b pend=%h want v=0 pend=91", valid8, pend8);
        end
        for (int i = 0; i < 6; i++) begin
            cyc();
            n_vec++;
            if ({valid8, idx8, pend8} !== {1'b1, eg[i], 8'h91}) begin
                n_err++;
                $display("FAIL rr_grant[%0d] got v=%0b idx=%0d pend=%h want v=1 idx=%0d pend=91",
                         i, valid8, idx8, pend8, eg[i]);
            end
        end
        req8 = 8'h00;
        for (int i = 0; i < 6; i++) begin
            cyc();
            n_vec++;
            if ({valid8, idx8, pend8, none8} !== {m_valid[0], 3'(m_idx[0]), 8'(m_pend[0]), m_none[0]}) begin
                n_err++;
                $display("FAIL rr_drain[%0d] got v=%0b idx=%0d pend=%h none=%0b want v=%0b idx=%0d pend=%h none=%0b",
                         i, valid8, idx8, pend8, none8, m_valid[0], m_idx[0], m_pend[0][7:0], m_none[0]);
            end
        end
        rdy8 = 1'b0;
    endtask

    task automatic test_mask();
        mode8 = 1'b0; mask8 = 8'h0F; rdy8 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req8 = (i == 0) ? 8'hF0 : 8'h00;
            cyc();
            n_vec++;
            if ({valid8, pend8, none8} !== {1'b0, 8'hF0, 1'b1}) begin
                n_err++;
                $display("FAIL mask_hold[%0d] got v=%0b pend=%h none=%0b want v=0 pend=f0 none=1",
                         i, valid8, pend8, none8);
            end
        end
        mask8 = 8'hFF;
        cyc();
        n_vec++;
        if ({valid8, idx8, none8} !== {1'b1, 3'd7, 1'b0}) begin
            n_err++;
            $display("FAIL mask_open got v=%0b idx=%0d none=%0b want v=1 idx=7 none=0", valid8, idx8, none8);
        end
        rdy8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            n_vec++;
            if ({valid8, idx8, pend8, none8} !== {m_valid[0], 3'(m_idx[0]), 8'(m_pend[0]), m_none[0]}) begin
                n_err++;
                $display("FAIL mask_drain[%0d] got v=%0b idx=%0d pend=%h none=%0b want v=%0b idx=%0d pend=%h none=%0b",
                         i, valid8, idx8, pend8, none8, m_valid[0], m_idx[0], m_pend[0][7:0], m_none[0]);
            end
        end
        rdy8 = 1'b0;
    endtask

    task automatic test_n5_reset();
        logic [4:0] ep[4] = '{5'h1F, 5'h1F, 5'h0F, 5'h07};
        logic       ev[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [2:0] ei[4] = '{3'd0, 3'd4, 3'd3, 3'd2};
        mode5 = 1'b1; mask5 = 5'h1F; rdy5 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req5 = (i == 0) ? 5'h1F : 5'h00;
            rdy5 = (i >= 2);
            cyc();
            n_vec++;
            if ({valid5, idx5, pend5} !== {ev[i], ei[i], ep[i]}) begin
                n_err++;
                $display("FAIL n5_grant[%0d] got v=%0b idx=%0d pend=%h want v=%0b idx=%0d pend=%h",
                         i, valid5, idx5, pend5, ev[i], ei[i], ep[i]);
            end
        end
        rst_n = 1'b0; rdy5 = 1'b0;
        cyc();
        rst_n = 1'b1;
        n_vec++;
        if ({valid5, none5, pend5, idx5} !== {1'b0, 1'b1, 5'h00, 3'd0}) begin
            n_err++;
            $display("FAIL n5_reset got v=%0b none=%0b pend=%h idx=%0d want v=0 none=1 pend=00 idx=0",
                     valid5, none5, pend5, idx5);
        end
        req5 = 5'h01;
        cyc();
        req5 = 5'h00;
        cyc();
        n_vec++;
        if ({valid5, idx5, pend5} !== {1'b1, 3'd0, 5'h01}) begin
            n_err++;
            $display("FAIL n5_after got v=%0b idx=%0d pend=%h want v=1 idx=0 pend=01", valid5, idx5, pend5);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            req8  = 8'($urandom & $urandom);
            mask8 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            if ($urandom_range(0, 15) == 0) mode8 = ~mode8;
            rdy8  = ($urandom_range(0, 3) != 0);
            req5  = 5'($urandom & $urandom);
            mask5 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h1F;
            if ($urandom_range(0, 15) == 0) mode5 = ~mode5;
            rdy5  = ($urandom_range(0, 3) != 0);
            cyc();
            n_vec++;
            if ({valid8, idx8, pend8, none8} !== {m_valid[0], 3'(m_idx[0]), 8'(m_pend[0]), m_none[0]}) begin
                n_err++;
                $display("FAIL rand8[%0d] got v=%0b idx=%0d pend=%h none=%0b want v=%0b idx=%0d pend=%h none=%0b",
                         i, valid8, idx8, pend8, none8, m_valid[0], m_idx[0], m_pend[0][7:0], m_none[0]);
            end
            n_vec++;
            if ({valid5, idx5, pend5, none5} !== {m_valid[1], 3'(m_idx[1]), 5'(m_pend[1]), m_none[1]}) begin
                n_err++;
                $display("FAIL rand5[%0d] got v=%0b idx=%0d pend=%h none=%0b want v=%0b idx=%0d pend=%h none=%0b",
                         i, valid5, idx5, pend5, none5, m_valid[1], m_idx[1], m_pend[1][4:0], m_none[1]);
            end
            n_vec++;
            if (idx5 > 3'd4) begin
                n_err++;
                $display("FAIL rand5_range[%0d] got idx=%0d want idx<=4", i, idx5);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = '0; m_valid[d] = 1'b0; m_idx[d] = 0; m_rr[d] = 0; m_none[d] = 1'b1;
        end
        test_reset();
        test_fixed();
        test_backpressure();
        test_round_robin();
        test_mask();
        test_n5_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pri_encoder_q.md
Name: pri_encoder_q

Overview:
- Parametrised, registered successor to the combinational 8-to-3 priority encoder.
- Captures request pulses into a pending register and applies a per-bit mask.
- Selects one index per grant, in fixed-priority mode or round-robin mode, and presents it on a valid/ready output handshake.
- Serves as the interrupt/event index source for the downstream controller; the accepted index clears its pending bit.

Parameters:
- N, 8, number of request lines (2..64).
- W, $clog2(N), index width (derived; not overridden by users).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- req, input, N, request lines; each high bit sampled per cycle sets the matching pending bit.
- mask, input, N, 1 = line enabled for selection; 0 = bit stays pending but is not selected.
- mode, input, 1, 0 = fixed priority (highest index wins); 1 = round-robin.
- out_idx, output, W, selected index; held stable while out_valid=1 and out_ready=0.
- out_valid, output, 1, out_idx is valid.
- out_ready, input, 1, consumer accepts out_idx when out_valid & out_ready.
- pending, output, N, current pending register (status readback).
- none, output, 1, registered; 1 when (pending & mask) == 0 after the current update (successor of inValid).

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - pending=0, out_valid=0, out_idx=0, none=1, rr_ptr=0.
  - Applies mid-handshake too: any held output is dropped and not retried.
- Accept is defined as acc = out_valid & out_ready.
- Pending update:
  - pending_next = (pending & ~clr) | req, where clr is the one-hot of out_idx when acc=1, else 0.
  - Set wins: req[k] and acceptance of index k in the same cycle leave pending[k]=1.
- Candidate vector: cand = pending & ~clr & mask. New req bits are excluded this cycle; this guarantees a 2-cycle minimum latency.
- Output load condition: (out_valid==0) | acc.
  - If load and cand != 0: out_valid<=1 and out_idx<=sel(cand).
  - If load and cand == 0: out_valid<=0; out_idx keeps its old value.
  - Otherwise out_valid and out_idx hold, even if mask, mode or pending change. The presented index is not revoked.
- Same-index guard: an index currently presented cannot be selected again for the next load, because its pending bit is cleared by the accept (clr).
- Fixed mode, sel: highest set index of cand (bit N-1 highest priority), identical ordering to the 8-bit encoder.
- Round-robin mode, sel:
  - Search descending starting at (rr_ptr-1) mod N, wrapping from 0 to N-1; the first set bit wins.
  - On every accept, rr_ptr <= accepted index, in either mode.
  - After reset (rr_ptr=0) the first search starts at N-1, so the first grant equals the fixed-mode result.
- Mode switching takes effect at the next load; no flush.
- Latency:
  - req high at edge k makes pending visible after edge k.
  - out_valid is high after edge k+1 at the earliest.
  - Throughput is one accept per cycle with out_ready held high.
- none <= ((pending_next & mask) == 0), registered; uses the current mask.
- Width rules: out_idx is a zero-extended W-bit index. For non-power-of-2 N, indices >= N never appear, and the round-robin wrap is mod N, not mod 2^W.

Decomposition:
- Package pri_encoder_pkg holds:
  - the function clog2_f;
  - the mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1.
- One sub-module, pri_find_n (parameter N): purely combinational "highest set bit at or below a start index, with wrap".
  - Inputs: vec[N-1:0], start[W-1:0].
  - Outputs: idx[W-1:0], found.
  - Fixed mode uses start=N-1; round-robin mode uses start=(rr_ptr-1) mod N.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst_n=0 for 3 cycles, then release with req=0, mask=FF.
  - Required: out_valid=0, none=1, pending=00, out_idx=0 for all cycles.
- Fixed priority:
  - Stimulus: mode=0, mask=FF; one-cycle req=0x2C at edge 5; out_ready=1 from edge 7.
  - Required: out_valid rises after edge 6; out_idx sequence 5,3,2 on consecutive accepts; pending goes 2C→0C→04→00; none=1 after the last accept.
- Backpressure/stability:
  - Stimulus: mode=0, out_ready=0; req=0x01, then req=0x80 two cycles later.
  - Required: out_idx stays 0 with out_valid=1. Raising out_ready gives accept of 0, then 7.
- Round-robin fairness:
  - Stimulus: mode=1, mask=FF; hold req=0x91 continuously; out_ready=1.
  - Required: grants cycle 7,4,0,7,4,0; pending stays 0x91 (set wins).
- Mask:
  - Stimulus: mask=0x0F; req=0xF0 pulse.
  - Required: pending=F0, out_valid=0, none=1. Changing mask to FF gives out_idx=7 after 1 cycle.
- Reset mid-operation with non-power-of-2 N:
  - Stimulus: N=5; req=0x1F, mode=1, accept twice, then rst_n=0 for one cycle.
  - Required: before reset, grants 4,3. After reset all state clears; the next req=0x01 gives out_idx=0; out_idx is never 5..7.
